// File: rtl/sap1_pkg.sv
// Shared SAP-1 memory arbiter parameters and FSM encoding.
package sap1_pkg;
   localparam int ADDR_W_D = 4;
   localparam int DATA_W_D = 8;
   localparam int BURST_MAX_D = 16;

   typedef enum logic [1:0] {
      S_CPU,
      S_HOLD,
      S_LOAD,
      S_REL
   } arb_state_t;
endpackage

// File: rtl/burst_counter.sv
// Loader beat counter; last flags that the next beat fills the burst.
module burst_counter #(
   parameter int MAX = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic last
);
   localparam int CW = $clog2(MAX) + 1;

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         count <= '0;
      end else if (inc && count != CW'(MAX)) begin
         count <= count + 1'b1;
      end
   end

   assign last = (count == CW'(MAX - 1));
endmodule

// File: rtl/mem_arbiter.sv
// Shares the SAP-1 RAM port between the CPU and a burst loader,
// handing over only at instruction boundaries.
module mem_arbiter
   import sap1_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_D,
   parameter int DATA_W = DATA_W_D,
   parameter int BURST_MAX = BURST_MAX_D
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_ce,
   input  logic              cpu_we,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_boundary,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_ce,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              ldr_ack,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              ldr_rvalid,
   output logic              cpu_hold,
   output logic              busy_err
);
   arb_state_t state;
   logic       block_flag;
   logic       bnd_q;
   logic       rd_pend;
   logic       last;
   logic       cpu_sel;

   // The CPU owns the port whenever reset is low, regardless of state.
   assign cpu_sel = !rst || state == S_CPU;

   always_comb begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_ce    = cpu_ce;
      ram_we    = cpu_we;
      ldr_ack   = 1'b0;
      if (!cpu_sel) begin
         ram_addr  = ldr_addr;
         ram_wdata = ldr_wdata;
         ram_ce    = 1'b0;
         ram_we    = 1'b0;
         if (state == S_LOAD && ldr_req) begin
            ram_ce  = 1'b1;
            ram_we  = ldr_we;
            ldr_ack = 1'b1;
         end
      end
   end

   burst_counter #(.MAX(BURST_MAX)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (state == S_REL),
      .inc  (ldr_ack),
      .last (last)
   );

   assign ldr_rvalid = rd_pend;
   assign ldr_rdata  = rd_pend ? ram_rdata : '0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= S_CPU;
         cpu_hold   <= 1'b0;
         block_flag <= 1'b0;
         busy_err   <= 1'b0;
         rd_pend    <= 1'b0;
         bnd_q      <= 1'b0;
      end else begin
         bnd_q   <= cpu_boundary;
         rd_pend <= ldr_ack && !ldr_we;
         if (cpu_hold && cpu_ce) busy_err <= 1'b1;
         // A falling boundary means one instruction has run.
         if (bnd_q && !cpu_boundary) block_flag <= 1'b0;
         case (state)
            S_CPU: begin
               if (ldr_req && cpu_boundary && !block_flag) begin
                  state    <= S_HOLD;
                  cpu_hold <= 1'b1;
               end
            end
            S_HOLD: state <= S_LOAD;
            S_LOAD: begin
               if (!ldr_req) begin
                  state <= S_REL;
               end else if (last) begin
                  state      <= S_REL;
                  block_flag <= 1'b1;
               end
            end
            S_REL: begin
               state    <= S_CPU;
               cpu_hold <= 1'b0;
            end
            default: state <= S_CPU;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and random bench for mem_arbiter against a
// transaction-level model of ownership, bursts and RAM contents.
module tb_mem_arbiter;
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] cpu_addr;
   logic       cpu_ce, cpu_we;
   logic [7:0] cpu_wdata;
   logic       cpu_boundary;
   logic       ldr_req, ldr_we;
   logic [3:0] ldr_addr;
   logic [7:0] ldr_wdata;
   logic [3:0] ram_addr;
   logic       ram_ce, ram_we;
   logic [7:0] ram_wdata, ram_rdata;
   logic       ldr_ack;
   logic [7:0] ldr_rdata;
   logic       ldr_rvalid, cpu_hold, busy_err;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .cpu_addr(cpu_addr), .cpu_ce(cpu_ce),
      .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
      .cpu_boundary(cpu_boundary),
      .ldr_req(ldr_req), .ldr_we(ldr_we),
      .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ram_addr(ram_addr), .ram_ce(ram_ce),
      .ram_we(ram_we), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .ldr_ack(ldr_ack),
      .ldr_rdata(ldr_rdata), .ldr_rvalid(ldr_rvalid),
      .cpu_hold(cpu_hold), .busy_err(busy_err)
   );

   always #5 clk = ~clk;

   logic [7:0] ram [16];
   always @(posedge clk) begin
      if (ram_ce && ram_we) ram[ram_addr] <= ram_wdata;
      if (ram_ce && !ram_we) ram_rdata <= ram[ram_addr];
   end

   int vectors = 0;
   int errors = 0;

   // Model: owner phase 0=cpu 1=turnaround 2=loading 3=release
   int         ph = 0, bt = 0;
   bit         blk = 0, pb = 0, er = 0, pd = 0;
   logic [7:0] pdat = 8'h00;
   logic [7:0] mm [16];

   logic       o_ack, o_hold, o_rvalid;
   logic [7:0] o_rdata;
   logic [3:0] o_addr;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      logic       e_ce, e_we, e_ack, ca;
      logic [3:0] e_a;
      logic [7:0] e_d;
      bit         grant, fill;
      #1;
      if (!rst || ph == 0) begin
         e_ce = cpu_ce; e_we = cpu_we;
         e_a = cpu_addr; e_d = cpu_wdata;
         e_ack = 1'b0; ca = 1'b1;
      end else if (ph == 2 && ldr_req) begin
         e_ce = 1'b1; e_we = ldr_we;
         e_a = ldr_addr; e_d = ldr_wdata;
         e_ack = 1'b1; ca = 1'b1;
      end else begin
         e_ce = 1'b0; e_we = 1'b0;
         e_a = ldr_addr; e_d = ldr_wdata;
         e_ack = 1'b0; ca = (ph == 2);
      end
      chk("ram_ce", 32'(ram_ce), 32'(e_ce));
      chk("ram_we", 32'(ram_we), 32'(e_we));
      if (ca) chk("ram_addr", 32'(ram_addr), 32'(e_a));
      if (e_ce && e_we)
         chk("ram_wdata", 32'(ram_wdata), 32'(e_d));
      chk("ldr_ack", 32'(ldr_ack), 32'(e_ack));
      chk("cpu_hold", 32'(cpu_hold), 32'(ph != 0));
      chk("ldr_rvalid", 32'(ldr_rvalid), 32'(pd));
      chk("ldr_rdata", 32'(ldr_rdata),
          pd ? 32'(pdat) : 32'd0);
      chk("busy_err", 32'(busy_err), 32'(er));
      o_ack = ldr_ack; o_hold = cpu_hold;
      o_rvalid = ldr_rvalid; o_rdata = ldr_rdata;
      o_addr = ram_addr;
      @(posedge clk);
      if (!rst) begin
         ph = 0; bt = 0; blk = 0;
         er = 0; pd = 0; pb = 0;
      end else begin
         pd = e_ack && !e_we;
         pdat = mm[e_a];
         if (ph != 0 && cpu_ce) er = 1;
         grant = 0; fill = 0;
         case (ph)
            0: grant = ldr_req && cpu_boundary && !blk;
            1: ph = 2;
            2: begin
               if (!ldr_req) ph = 3;
               else begin
                  bt++;
                  if (bt == 16) begin
                     ph = 3; fill = 1;
                  end
               end
            end
            default: begin ph = 0; bt = 0; end
         endcase
         if (grant) ph = 1;
         if (fill) blk = 1;
         else if (pb && !cpu_boundary) blk = 0;
         pb = cpu_boundary;
      end
      if (e_ce && e_we) mm[e_a] = e_d;
      @(negedge clk);
   endtask

   task automatic drain();
      ldr_req = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      int na, nh, ka, kr, k, acks;
      logic [7:0] rd;
      logic [7:0] bv;
      rst = 1'b0; cpu_addr = '0; cpu_ce = 0; cpu_we = 0;
      cpu_wdata = '0; cpu_boundary = 0; ldr_req = 0;
      ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
      for (int i = 0; i < 16; i++) begin
         ram[i] = 8'(8'h10 + i * 7);
         mm[i] = ram[i];
      end
      ram[9] = 8'hA7; mm[9] = 8'hA7;
      ram[2] = 8'h5D; mm[2] = 8'h5D;
      @(negedge clk);
      tick(); tick();
      chk("rst_hold", 32'(cpu_hold), 32'd0);
      chk("rst_err", 32'(busy_err), 32'd0);
      rst = 1'b1;

      // Loader write waits for the boundary.
      ldr_req = 1; ldr_we = 1; ldr_addr = 5;
      ldr_wdata = 8'h3C; nh = 0;
      repeat (3) begin tick(); nh += o_hold; end
      chk("w_wait", 32'(nh), 32'd0);
      cpu_boundary = 1; na = 0; nh = 0; ka = -1;
      for (int j = 0; j < 12; j++) begin
         tick(); na += o_ack; nh += o_hold;
         if (o_ack) begin ka = j; ldr_req = 0; end
      end
      chk("w_acks", 32'(na), 32'd1);
      chk("w_ackcyc", 32'(ka), 32'd2);
      chk("w_hold", 32'(nh), 32'd4);
      chk("w_ram5", 32'(ram[5]), 32'h3C);

      // Loader read returns one cycle after the ack.
      ldr_req = 1; ldr_we = 0; ldr_addr = 9;
      ka = -1; kr = -1; rd = '0;
      for (int j = 0; j < 12; j++) begin
         tick();
         if (o_ack) begin ka = j; ldr_req = 0; end
         if (o_rvalid) begin kr = j; rd = o_rdata; end
      end
      chk("r_lat", 32'(kr), 32'(ka + 1));
      chk("r_data", 32'(rd), 32'hA7);

      // Grant cycle still serves the CPU read.
      cpu_ce = 1; cpu_we = 0; cpu_addr = 2;
      ldr_req = 1; ldr_addr = 2;
      tick();
      chk("c_rdata", 32'(ram_rdata), 32'h5D);
      cpu_ce = 0;
      tick();
      chk("c_hold", 32'(o_hold), 32'd1);
      for (int j = 0; j < 6; j++) begin
         tick();
         if (o_ack) ldr_req = 0;
      end
      drain();

      // 20-beat request: 16 beats, then wait for a boundary.
      ldr_req = 1; ldr_we = 1; acks = 0;
      ldr_addr = 0; ldr_wdata = 8'h55; nh = 0;
      for (int j = 0; j < 30; j++) begin
         tick();
         if (j >= 20) nh += o_hold;
         if (o_ack) begin
            acks++;
            bv = 8'(acks);
            ldr_addr = bv[3:0];
            ldr_wdata = bv ^ 8'h55;
         end
      end
      chk("b_acks16", 32'(acks), 32'd16);
      chk("b_noregrant", 32'(nh), 32'd0);
      cpu_boundary = 0; tick();
      cpu_boundary = 1;
      for (int j = 0; j < 20; j++) begin
         tick();
         if (o_ack) begin
            acks++;
            bv = 8'(acks);
            ldr_addr = bv[3:0];
            ldr_wdata = bv ^ 8'h55;
            if (acks == 20) ldr_req = 0;
         end
      end
      chk("b_acks20", 32'(acks), 32'd20);
      chk("b_ram3", 32'(ram[3]), 32'h46);
      chk("b_ram15", 32'(ram[15]), 32'h5A);
      drain();

      // Reset lands on the third beat of a read burst.
      ldr_req = 1; ldr_we = 0; ldr_addr = 1;
      acks = 0; k = 0;
      while (acks < 2 && k < 10) begin
         tick(); acks += o_ack; k++;
      end
      chk("x_pre", 32'(acks), 32'd2);
      rst = 0; tick();
      rst = 1; cpu_boundary = 0;
      cpu_ce = 1; cpu_addr = 4;
      tick();
      chk("x_hold", 32'(o_hold), 32'd0);
      chk("x_ack", 32'(o_ack), 32'd0);
      chk("x_rv", 32'(o_rvalid), 32'd0);
      chk("x_addr", 32'(o_addr), 32'd4);
      chk("x_cnt", 32'(dut.u_cnt.count), 32'd0);
      cpu_ce = 0;
      drain();

      // CPU access while held is blocked and flagged.
      cpu_boundary = 1; ldr_req = 1; ldr_addr = 3;
      k = 0; acks = 0;
      while (acks == 0 && k < 8) begin
         tick(); acks += o_ack; k++;
      end
      cpu_ce = 1; cpu_addr = 4'hF;
      tick();
      chk("e_addr", 32'(o_addr), 32'd3);
      cpu_ce = 0; ldr_req = 0;
      tick();
      chk("e_err", 32'(busy_err), 32'd1);
      repeat (6) tick();
      chk("e_sticky", 32'(busy_err), 32'd1);
      rst = 0; tick(); rst = 1; tick();
      chk("e_clr", 32'(busy_err), 32'd0);

      // Random traffic against the model.
      for (int j = 0; j < 800; j++) begin
         rst = ($urandom_range(0, 149) != 0);
         if ($urandom_range(0, 3) == 0)
            cpu_boundary = ~cpu_boundary;
         if ($urandom_range(0, 4) == 0)
            ldr_req = ~ldr_req;
         ldr_we = 1'($urandom);
         ldr_addr = 4'($urandom);
         ldr_wdata = 8'($urandom);
         cpu_ce = (ph != 0) ?
                  ($urandom_range(0, 49) == 0) :
                  1'($urandom);
         cpu_we = 1'($urandom);
         cpu_addr = 4'($urandom);
         cpu_wdata = 8'($urandom);
         tick();
      end
      rst = 1; cpu_ce = 0; drain();
      for (int i = 0; i < 16; i++)
         chk("mem", 32'(ram[i]), 32'(mm[i]));

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errors);
      $finish;
   end
endmodule
